// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO.
// Bytes are popped on START entry and shifted out LSB first.
module uart_tx_fifo #(
  parameter int CLK_HZ       = 100000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int FIFO_AW      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       ovf,
  output logic       tx_busy,
  output logic       tx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               full_q, empty_q;
  logic               ovf_q, ovf_d;
  logic               push, pop;

  state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       tx_q, tx_d;
  logic       busy_q;
  logic       baud_last;

  assign push = wr_en & ~full_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q | (wr_en & full_q);
    if (push) wptr_d = wptr_q + FIFO_AW'(1);
    if (pop)  rptr_d = rptr_q + FIFO_AW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (FIFO_AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (FIFO_AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          sh_d    = mem_q[rptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        tx_d = sh_q[0];
        if (baud_last) begin
          baud_d = '0;
          sh_d   = {1'b0, sh_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!empty_q) begin
            // Chain straight into the next frame with no idle bit.
            pop     = 1'b1;
            sh_d    = mem_q[rptr_q];
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_FULL);
      empty_q <= (cnt_d == '0);
      ovf_q   <= ovf_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= (state_q != IDLE);
    end
  end

  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign ovf        = ovf_q;
  assign tx_busy    = busy_q;
  assign tx         = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo, run at 16 clocks per bit.
// Line samples are taken on the falling clock edge.
module tb_uart_tx_fifo;

  localparam int CPB = 16;
  localparam int CLK_HZ = CPB * 115200;
  localparam int LIM = 40 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       fifo_full, fifo_empty, ovf, tx_busy, tx;

  int ntests = 0;
  int nfail = 0;

  uart_tx_fifo #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (115200),
    .FIFO_AW(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .ovf       (ovf),
    .tx_busy   (tx_busy),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Starts on the first sample of a start bit; records mid-bit values,
  // samples that disagree with their bit's first sample, busy-low samples.
  task automatic capture_line(output logic [9:0] bits,
                              output int glitch, output int nbusy);
    logic first;
    glitch = 0;
    nbusy = 0;
    bits = '0;
    for (int i = 0; i < 10; i++) begin
      first = tx;
      for (int j = 0; j < CPB; j++) begin
        if (tx !== first) glitch++;
        if (j == CPB / 2) bits[i] = tx;
        if (tx_busy !== 1'b1) nbusy++;
        @(negedge clk);
      end
    end
  endtask

  task automatic rx_byte(output logic [7:0] d, output bit ok,
                         output int waited);
    logic [9:0] bits;
    int g, nb;
    waited = 0;
    while (tx !== 1'b0 && waited < LIM) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= LIM) begin
      d = 8'h00;
      ok = 1'b0;
    end else begin
      capture_line(bits, g, nb);
      d = bits[8:1];
      ok = (bits[0] == 1'b0) && (bits[9] == 1'b1) && (g == 0) && (nb == 0);
    end
  endtask

  task automatic count_low(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      if (tx !== 1'b1) lows++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int e_tx, e_bz, e_em, e_fl, e_ov;
    e_tx = 0; e_bz = 0; e_em = 0; e_fl = 0; e_ov = 0;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      if (tx !== 1'b1) e_tx++;
      if (tx_busy !== 1'b0) e_bz++;
      if (fifo_empty !== 1'b1) e_em++;
      if (fifo_full !== 1'b0) e_fl++;
      if (ovf !== 1'b0) e_ov++;
      @(negedge clk);
    end
    ntests++; if (e_tx != 0) begin nfail++; $display("FAIL rst_tx bad_cycles=%0d exp=0", e_tx); end
    ntests++; if (e_bz != 0) begin nfail++; $display("FAIL rst_busy bad_cycles=%0d exp=0", e_bz); end
    ntests++; if (e_em != 0) begin nfail++; $display("FAIL rst_empty bad_cycles=%0d exp=0", e_em); end
    ntests++; if (e_fl != 0) begin nfail++; $display("FAIL rst_full bad_cycles=%0d exp=0", e_fl); end
    ntests++; if (e_ov != 0) begin nfail++; $display("FAIL rst_ovf bad_cycles=%0d exp=0", e_ov); end
  endtask

  task automatic test_single();
    logic [9:0] bits;
    int g, nb;
    push(8'h41);
    ntests++; if (fifo_empty !== 1'b0) begin nfail++; $display("FAIL single_empty_n got=%b exp=0", fifo_empty); end
    tick(1);
    ntests++; if (tx !== 1'b1) begin nfail++; $display("FAIL single_tx_n1 got=%b exp=1", tx); end
    ntests++; if (fifo_empty !== 1'b1) begin nfail++; $display("FAIL single_empty_n1 got=%b exp=1", fifo_empty); end
    tick(1);
    ntests++; if (tx !== 1'b0) begin nfail++; $display("FAIL single_tx_n2 got=%b exp=0", tx); end
    capture_line(bits, g, nb);
    ntests++; if (bits !== 10'b1010000010) begin nfail++; $display("FAIL single_line got=%b exp=1010000010", bits); end
    ntests++; if (g != 0) begin nfail++; $display("FAIL single_bitlen glitches=%0d exp=0", g); end
    ntests++; if (nb != 0) begin nfail++; $display("FAIL single_busy_in_frame low=%0d exp=0", nb); end
    ntests++; if (tx_busy !== 1'b0) begin nfail++; $display("FAIL single_busy_end got=%b exp=0", tx_busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [7] = '{8'h48, 8'h45, 8'h4c, 8'h4c, 8'h4f, 8'h0d, 8'h0a};
    logic [7:0] got [7];
    int wt [7];
    bit okv [7];
    string s;
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          wr_en = 1'b1;
          wr_data = msg[i];
          @(negedge clk);
        end
        wr_en = 1'b0;
      end
      begin
        for (int k = 0; k < 7; k++) rx_byte(got[k], okv[k], wt[k]);
      end
    join
    for (int k = 0; k < 7; k++) begin
      ntests++; if (got[k] !== msg[k] || !okv[k]) begin nfail++; $display("FAIL b2b_byte%0d got=%h ok=%0d exp=%h", k, got[k], okv[k], msg[k]); end
      if (k > 0) begin
        ntests++; if (wt[k] != 0) begin nfail++; $display("FAIL b2b_gap%0d got=%0d exp=0", k, wt[k]); end
      end
    end
    s = "";
    for (int k = 0; k < 5; k++) s = {s, $sformatf("%c", got[k])};
    $display("[TB] model got %s", s);
    if (got[5] == 8'h0d && got[6] == 8'h0a) $display("[TB] model got newline");
    ntests++; if (ovf !== 1'b0) begin nfail++; $display("FAIL b2b_ovf got=%b exp=0", ovf); end
    ntests++; if (tx_busy !== 1'b0) begin nfail++; $display("FAIL b2b_busy_end got=%b exp=0", tx_busy); end
  endtask

  task automatic test_overflow();
    logic [7:0] got [9];
    int wt [9];
    bit okv [9];
    int lows;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          wr_en = 1'b1;
          wr_data = 8'h30 + 8'(i);
          @(negedge clk);
          if (i == 7) begin
            ntests++; if (fifo_full !== 1'b0) begin nfail++; $display("FAIL ovf_full_e7 got=%b exp=0", fifo_full); end
          end
          if (i == 8) begin
            ntests++; if (fifo_full !== 1'b1) begin nfail++; $display("FAIL ovf_full_e8 got=%b exp=1", fifo_full); end
            ntests++; if (ovf !== 1'b0) begin nfail++; $display("FAIL ovf_early got=%b exp=0", ovf); end
          end
        end
        wr_en = 1'b0;
        ntests++; if (ovf !== 1'b1) begin nfail++; $display("FAIL ovf_set got=%b exp=1", ovf); end
      end
      begin
        for (int k = 0; k < 9; k++) rx_byte(got[k], okv[k], wt[k]);
      end
    join
    for (int k = 0; k < 9; k++) begin
      ntests++; if (got[k] !== 8'h30 + 8'(k) || !okv[k]) begin nfail++; $display("FAIL ovf_byte%0d got=%h ok=%0d exp=%h", k, got[k], okv[k], 8'h30 + 8'(k)); end
    end
    count_low(12 * CPB, lows);
    ntests++; if (lows != 0) begin nfail++; $display("FAIL ovf_extra_frame low=%0d exp=0", lows); end
    ntests++; if (fifo_empty !== 1'b1) begin nfail++; $display("FAIL ovf_drained got=%b exp=1", fifo_empty); end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] bits;
    int g, nb, lows;
    push(8'h5A);
    tick(2);
    tick(4 * CPB + CPB / 2);
    ntests++; if (tx_busy !== 1'b1) begin nfail++; $display("FAIL mid_busy_pre got=%b exp=1", tx_busy); end
    ntests++; if (ovf !== 1'b1) begin nfail++; $display("FAIL mid_ovf_sticky got=%b exp=1", ovf); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ntests++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin nfail++; $display("FAIL mid_abort tx=%b busy=%b exp=1,0", tx, tx_busy); end
    ntests++; if (fifo_empty !== 1'b1 || ovf !== 1'b0) begin nfail++; $display("FAIL mid_flags empty=%b ovf=%b exp=1,0", fifo_empty, ovf); end
    count_low(12 * CPB, lows);
    ntests++; if (lows != 0 || tx_busy !== 1'b0) begin nfail++; $display("FAIL mid_no_frame low=%0d busy=%b exp=0,0", lows, tx_busy); end
    push(8'h55);
    tick(2);
    ntests++; if (tx !== 1'b0) begin nfail++; $display("FAIL mid_restart_tx got=%b exp=0", tx); end
    capture_line(bits, g, nb);
    ntests++; if (bits !== 10'b1010101010 || g != 0) begin nfail++; $display("FAIL mid_line got=%b glitch=%0d exp=1010101010,0", bits, g); end
  endtask

  task automatic test_full_pop_push();
    logic [7:0] exp [10];
    logic [7:0] got [10];
    int wt [10];
    bit okv [10];
    int lows;
    do_reset();
    for (int i = 0; i < 9; i++) exp[i] = 8'h61 + 8'(i);
    exp[9] = 8'h7A;
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          wr_en = 1'b1;
          wr_data = exp[i];
          @(negedge clk);
        end
        wr_en = 1'b0;
        tick(10 * CPB - 8);
        ntests++; if (fifo_full !== 1'b1 || ovf !== 1'b0) begin nfail++; $display("FAIL fp_pre full=%b ovf=%b exp=1,0", fifo_full, ovf); end
        wr_en = 1'b1;
        wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0;
        ntests++; if (fifo_full !== 1'b0 || ovf !== 1'b1) begin nfail++; $display("FAIL fp_drop full=%b ovf=%b exp=0,1", fifo_full, ovf); end
        push(8'h7A);
        ntests++; if (fifo_full !== 1'b1) begin nfail++; $display("FAIL fp_refill got=%b exp=1", fifo_full); end
      end
      begin
        for (int k = 0; k < 10; k++) rx_byte(got[k], okv[k], wt[k]);
      end
    join
    for (int k = 0; k < 10; k++) begin
      ntests++; if (got[k] !== exp[k] || !okv[k]) begin nfail++; $display("FAIL fp_byte%0d got=%h ok=%0d exp=%h", k, got[k], okv[k], exp[k]); end
    end
    count_low(12 * CPB, lows);
    ntests++; if (lows != 0) begin nfail++; $display("FAIL fp_extra_frame low=%0d exp=0", lows); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_full_pop_push();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
